ysyx_24120013_core_ctrl: RTL

YSYX_24120013_CORE_CTRL -- requirements
Module: ysyx_24120013_core_ctrl

---
 rtl/ysyx_24120013_core_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_24120013_core_ctrl.sv
// Multi-cycle core sequencer: IDLE -> FETCH -> DECODE -> EXECUTE -> WB -> FETCH ...,
// with ebreak (and optionally a fetch watchdog) parking the core in HALT.
// Optional fetch-timeout watchdog: define YSYX_24120013_CORE_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | imem_req high, waiting for imem_ready to capture inst
// DECODE  | one cycle; ebreak -> HALT, else EXECUTE
// EXECUTE | exu_go strobe
// WB      | pc_update strobe, optional rf_wen, retire count
// HALT    | sticky stop, left only by reset
module ysyx_24120013_core_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        imem_ready,
  input  logic [31:0] inst,
  output logic        imem_req,
  output logic [31:0] ir,
  output logic        exu_go,
  output logic        rf_wen,
  output logic        pc_update,
  output logic        busy,
  output logic        halt,
  output logic        timeout_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WB, S_HALT
  } state_e;

  localparam logic [31:0] EBREAK = 32'h00100073;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic        imem_req_q, imem_req_d;
  logic        exu_go_q, exu_go_d;
  logic        rf_wen_q, rf_wen_d;
  logic        pc_update_q, pc_update_d;
  logic        busy_q, busy_d;
  logic        halt_q, halt_d;

`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;
`endif

  // Instructions that write a destination register, excluding rd=x0.
  function automatic logic writes_rd(input logic [31:0] w);
    logic op_ok;
    case (w[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: op_ok = 1'b1;
      default:                            op_ok = 1'b0;
    endcase
    return op_ok && (w[11:7] != 5'd0);
  endfunction

  // Next-state, next-IR, retire count and registered strobes derived from next state.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    inst_cnt_d = inst_cnt_q;
`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = inst;
          state_d = S_DECODE;
        end
`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_DECODE:  state_d = (ir_q == EBREAK) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_d = S_WB;
      S_WB: begin
        inst_cnt_d = inst_cnt_q + 32'd1;
        state_d    = S_FETCH;
`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase

    imem_req_d  = (state_d == S_FETCH);
    exu_go_d    = (state_d == S_EXECUTE);
    pc_update_d = (state_d == S_WB);
    rf_wen_d    = (state_d == S_WB) && writes_rd(ir_d);
    busy_d      = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                  (state_d == S_EXECUTE) || (state_d == S_WB);
    halt_d      = (state_d == S_HALT);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      inst_cnt_q  <= '0;
      imem_req_q  <= 1'b0;
      exu_go_q    <= 1'b0;
      rf_wen_q    <= 1'b0;
      pc_update_q <= 1'b0;
      busy_q      <= 1'b0;
      halt_q      <= 1'b0;
`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      inst_cnt_q  <= inst_cnt_d;
      imem_req_q  <= imem_req_d;
      exu_go_q    <= exu_go_d;
      rf_wen_q    <= rf_wen_d;
      pc_update_q <= pc_update_d;
      busy_q      <= busy_d;
      halt_q      <= halt_d;
`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign ir        = ir_q;
  assign exu_go    = exu_go_q;
  assign rf_wen    = rf_wen_q;
  assign pc_update = pc_update_q;
  assign busy      = busy_q;
  assign halt      = halt_q;
  assign inst_cnt  = inst_cnt_q;

`ifdef YSYX_24120013_CORE_CTRL_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  // No watchdog in this build: FETCH waits forever and the flag is constant zero.
  assign timeout_err = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

endmodule
